adder_host: RTL and testbench

Bit-serial host front end for the registered 4-bit carry-look-ahead adder (`toplevel`). It collects an operand frame serially, drives `x`, `y` and `cin` into the adder, and waits out the adder's input and output register stages. It then captures `z` and `cout` and returns the result serially. It is the initiator end of the adder's operand/result interface and sits between a narrow serial link and the adder instance.

---
 rtl/adder_host_pkg.sv | 19 +
 rtl/adder_host_shift.sv | 27 ++
 rtl/adder_host.sv | 154 +++++++++++++++
 tb/tb_adder_host.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_host_pkg.sv
// Shared types and frame-length helpers for the adder_host serial front end.
package adder_host_pkg;

    typedef enum logic [1:0] {LOAD, WAIT, SHIFT} state_t;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned IN_FRAME_LEN  = 2 * DEF_WIDTH + 1;
    localparam int unsigned OUT_FRAME_LEN = DEF_WIDTH + 1;

    // Frame lengths for a non-default operand width.
    function automatic int unsigned in_frame_len(input int unsigned width);
        return 2 * width + 1;
    endfunction

    function automatic int unsigned out_frame_len(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/adder_host_shift.sv
// Right-shifting register with parallel load, serial MSB input and LSB tap.
module adder_host_shift #(
    parameter int unsigned LEN = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [LEN-1:0] load_data,
    input  logic           shift,
    input  logic           shift_in,
    output logic [LEN-1:0] data,
    output logic           lsb
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {shift_in, data[LEN-1:1]};
        end
    end

    assign lsb = data[0];

endmodule

// File: rtl/adder_host.sv
// Serial host for the registered CLA adder: collects operands, waits out the adder
// pipeline, returns {cout,z} serially. ADDER_HOST_CHECK_EN adds a sticky result checker.
module adder_host
    import adder_host_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_bit,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [WIDTH:1] x,
    output logic [WIDTH:1] y,
    output logic           cin,
    input  logic [WIDTH:1] z,
    input  logic           cout,
    output logic           out_bit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           err
);

    localparam int unsigned IN_LEN  = in_frame_len(WIDTH);
    localparam int unsigned OUT_LEN = out_frame_len(WIDTH);
    localparam int unsigned IN_CW   = $clog2(2 * WIDTH + 2);
    localparam int unsigned WAIT_CW = $clog2(ADD_LAT + 2);

    state_t               state;
    logic [IN_CW-1:0]     in_cnt;
    logic [WAIT_CW-1:0]   wait_cnt;
    logic [IN_LEN-1:0]    op_data;
    logic [IN_LEN-1:0]    frame;
    logic [OUT_LEN-1:0]   res_data_unused;
    logic                 op_lsb_unused;
    logic                 op_shift;
    logic                 issue;
    logic                 capture;
    logic                 res_shift;

    assign op_shift  = (state == LOAD) && in_valid;
    assign issue     = op_shift && (in_cnt == IN_CW'(IN_LEN - 1));
    assign capture   = (state == WAIT) && (wait_cnt == WAIT_CW'(ADD_LAT));
    assign res_shift = (state == SHIFT) && out_ready;

    // The issuing bit is still on in_bit, so the complete frame is the register plus it.
    assign frame = {in_bit, op_data[IN_LEN-1:1]};

    adder_host_shift #(
        .LEN (IN_LEN)
    ) u_op_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ({IN_LEN{1'b0}}),
        .shift     (op_shift),
        .shift_in  (in_bit),
        .data      (op_data),
        .lsb       (op_lsb_unused)
    );

    adder_host_shift #(
        .LEN (OUT_LEN)
    ) u_res_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .load_data ({cout, z}),
        .shift     (res_shift),
        .shift_in  (1'b0),
        .data      (res_data_unused),
        .lsb       (out_bit)
    );

    // in_cnt doubles as the output bit counter while in SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            in_cnt   <= '0;
            wait_cnt <= '0;
            x        <= '0;
            y        <= '0;
            cin      <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (issue) begin
                        x        <= frame[WIDTH-1:0];
                        y        <= frame[2*WIDTH-1:WIDTH];
                        cin      <= frame[2*WIDTH];
                        in_cnt   <= '0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else if (op_shift) begin
                        in_cnt <= in_cnt + IN_CW'(1);
                    end
                end
                WAIT: begin
                    if (capture) begin
                        wait_cnt <= '0;
                        state    <= SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CW'(1);
                    end
                end
                SHIFT: begin
                    if (res_shift) begin
                        if (in_cnt == IN_CW'(OUT_LEN - 1)) begin
                            in_cnt   <= '0;
                            wait_cnt <= '0;
                            state    <= LOAD;
                        end else begin
                            in_cnt <= in_cnt + IN_CW'(1);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == SHIFT);
    assign busy      = (state != LOAD) || (in_cnt != '0);

`ifdef ADDER_HOST_CHECK_EN
    logic [WIDTH:0] ref_sum;
    logic           err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_sum <= '0;
            err_q   <= 1'b0;
        end else begin
            if (issue) begin
                ref_sum <= {1'b0, frame[WIDTH-1:0]} + {1'b0, frame[2*WIDTH-1:WIDTH]}
                         + (WIDTH+1)'(frame[2*WIDTH]);
            end
            if (capture && ({cout, z} != ref_sum)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_host.sv
// Directed self-checking bench for adder_host with a behavioural two-stage adder model.
module tb_adder_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       fault = 1'b0;
    logic [4:1] x, y, z;
    logic       cin, cout;
    logic       in_ready, out_bit, out_valid, busy, err;
    logic [4:1] ax, ay;
    logic       ac;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    adder_host dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .z         (z),
        .cout      (cout),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    // Registered adder: input flops then output flops; fault flips z[1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ax <= '0; ay <= '0; ac <= 1'b0; z <= '0; cout <= 1'b0;
        end else begin
            ax <= x; ay <= y; ac <= cin;
            {cout, z} <= ({1'b0, ax} + {1'b0, ay} + {4'b0, ac}) ^ {4'b0, fault};
        end
    end

    // All tasks start and end on a falling edge.
    task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [8:0] f;
        f = {c, b, a};
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_bit   = f[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic recv_frame(output logic [4:0] r);
        int cyc;
        for (int i = 0; i < 5; i++) begin
            wait_valid(cyc);
            r[i] = out_valid ? out_bit : 1'bx;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({x, y, cin} !== 9'd0) $display("FAIL reset_xyc: got %h want 0", {x, y, cin});
        else passed++;
        total++;
        if ({out_bit, out_valid, in_ready, busy, err} !== 5'b00100)
            $display("FAIL reset_ctrl: got %b want 00100", {out_bit, out_valid, in_ready, busy, err});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        logic [4:0] r;
        send_frame(4'd3, 4'd5, 1'b0);
        total++;
        if ({x, y, cin, in_ready, busy} !== {4'd3, 4'd5, 1'b0, 1'b0, 1'b1})
            $display("FAIL basic_issue: got %h want %h", {x, y, cin, in_ready, busy},
                     {4'd3, 4'd5, 1'b0, 1'b0, 1'b1});
        else passed++;
        wait_valid(cyc);
        total++;
        if (cyc !== 3) $display("FAIL basic_latency: got %0d want 3", cyc);
        else passed++;
        recv_frame(r);
        total++;
        if (r !== 5'b01000) $display("FAIL basic_result: got %b want 01000", r);
        else passed++;
        total++;
        if ({in_ready, busy, out_valid, err} !== 4'b1000)
            $display("FAIL basic_done: got %b want 1000", {in_ready, busy, out_valid, err});
        else passed++;
    endtask

    task automatic test_wrap;
        logic [4:0] r;
        send_frame(4'd15, 4'd15, 1'b1);
        recv_frame(r);
        total++;
        if (r !== 5'b11111) $display("FAIL wrap_result: got %b want 11111", r);
        else passed++;
    endtask

    task automatic test_backpressure;
        int cyc;
        logic [4:0] r;
        logic stable;
        out_ready = 1'b0;
        send_frame(4'd7, 4'd8, 1'b0);
        wait_valid(cyc);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_bit !== 1'b1 || x !== 4'd7 || y !== 4'd8 || in_ready !== 1'b0
                || out_valid !== 1'b1) stable = 1'b0;
            @(negedge clk);
        end
        total++;
        if (stable !== 1'b1) $display("FAIL bp_stall: got %b want 1", stable);
        else passed++;
        out_ready = 1'b1;
        recv_frame(r);
        total++;
        if (r !== 5'b01111) $display("FAIL bp_result: got %b want 01111", r);
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({x, y, cin, in_ready, busy, out_valid} !== {9'd0, 3'b100})
            $display("FAIL midrst_state: got %h want %h", {x, y, cin, in_ready, busy, out_valid},
                     {9'd0, 3'b100});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        send_frame(4'd1, 4'd2, 1'b0);
        total++;
        if ({x, y, cin} !== {4'd1, 4'd2, 1'b0})
            $display("FAIL midrst_issue: got %h want %h", {x, y, cin}, {4'd1, 4'd2, 1'b0});
        else passed++;
        recv_frame(r);
        total++;
        if (r !== 5'b00011) $display("FAIL midrst_result: got %b want 00011", r);
        else passed++;
    endtask

    task automatic test_checker;
        int cyc;
        logic [4:0] r;
        logic exp_err;
`ifdef ADDER_HOST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        fault = 1'b1;
        send_frame(4'd2, 4'd2, 1'b0);
        wait_valid(cyc);
        total++;
        if (err !== exp_err) $display("FAIL chk_capture: got %b want %b", err, exp_err);
        else passed++;
        recv_frame(r);
        total++;
        if (r !== 5'b00101) $display("FAIL chk_faulty_result: got %b want 00101", r);
        else passed++;
        fault = 1'b0;
        send_frame(4'd6, 4'd7, 1'b1);
        recv_frame(r);
        total++;
        if (r !== 5'b01110) $display("FAIL chk_good_result: got %b want 01110", r);
        else passed++;
        total++;
        if (err !== exp_err) $display("FAIL chk_sticky: got %b want %b", err, exp_err);
        else passed++;
    endtask

    task automatic test_idle_input;
        logic [4:0] r;
        send_frame(4'd9, 4'd4, 1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        recv_frame(r);
        in_valid = 1'b0;
        total++;
        if (r !== 5'b01101) $display("FAIL idle_result: got %b want 01101", r);
        else passed++;
        total++;
        if ({busy, in_ready} !== 2'b01)
            $display("FAIL idle_unconsumed: got %b want 01", {busy, in_ready});
        else passed++;
        send_frame(4'd10, 4'd3, 1'b1);
        recv_frame(r);
        total++;
        if (r !== 5'b01110) $display("FAIL idle_next: got %b want 01110", r);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_reset_mid;
        test_checker;
        test_idle_input;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
